// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, constants and PC helper.
package if_pkg;

  localparam int IF_XLEN = 32;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  localparam logic [IF_XLEN-1:0] INST_NOP = 32'h0000_0013;

  function automatic logic [IF_XLEN-1:0] pc_next(input logic [IF_XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and the IR stage.
interface inst_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            io_redirect_valid;
  logic [XLEN-1:0] io_redirect_pc;
  logic            io_imem_req_valid;
  logic            io_imem_req_ready;
  logic [XLEN-1:0] io_imem_req_addr;
  logic            io_imem_resp_valid;
  logic [XLEN-1:0] io_imem_resp_data;
  logic            io_inst_valid;
  logic            io_inst_ready;
  logic [XLEN-1:0] io_inst;
  logic [XLEN-1:0] io_inst_pc;

  modport master (
    input  io_redirect_valid, io_redirect_pc,
    output io_imem_req_valid, io_imem_req_addr,
    input  io_imem_req_ready,
    input  io_imem_resp_valid, io_imem_resp_data,
    output io_inst_valid, io_inst, io_inst_pc,
    input  io_inst_ready
  );

  modport slave (
    output io_redirect_valid, io_redirect_pc,
    input  io_imem_req_valid, io_imem_req_addr,
    output io_imem_req_ready,
    output io_imem_resp_valid, io_imem_resp_data,
    input  io_inst_valid, io_inst, io_inst_pc,
    output io_inst_ready
  );
endinterface

// File: rtl/inst_fetch_unit_fifo.sv
// Prefetch FIFO holding {pc, inst} pairs; clear wins over push and pop, head read combinationally.
module fetch_fifo #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [2*XLEN-1:0]          wdata_i,
  output logic [2*XLEN-1:0]          rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2*XLEN-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !clear_i;
  assign do_pop  = pop_i && !clear_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage carries no reset; empty_o gates everything downstream
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  push_when_full_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full_o && !clear_i));

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, in-order response buffering and
// redirect handling that discards responses to requests made before the redirect.
module inst_fetch_unit
  import if_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  inst_fetch_unit_if.master io
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0]     outst_q, outst_d, drop_q, drop_d;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  logic [2*XLEN-1:0] head;
  logic              redirect, req_fire, resp, push, pop;
  logic [XLEN-1:0]   redirect_pc_al;

  assign redirect       = io.io_redirect_valid;
  assign resp           = io.io_imem_resp_valid;
  assign redirect_pc_al = io.io_redirect_pc & ~XLEN'(3);

  // total credit covers buffered words plus requests still owed a response
  assign io.io_imem_req_valid = (state_q != BOOT) && !redirect && !fifo_full &&
                                ((int'(fifo_count) + int'(outst_q)) < DEPTH);
  assign io.io_imem_req_addr  = fetch_pc_q;
  assign req_fire             = io.io_imem_req_valid && io.io_imem_req_ready;

  assign push = resp && (drop_q == '0) && !redirect;
  assign pop  = !fifo_empty && io.io_inst_ready;

  assign io.io_inst_valid = !fifo_empty;
  assign io.io_inst       = fifo_empty ? '0 : head[XLEN-1:0];
  assign io.io_inst_pc    = fifo_empty ? '0 : head[2*XLEN-1:XLEN];

  fetch_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clear_i (redirect),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({resp_pc_q, io.io_imem_resp_data}),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    outst_d    = outst_q + CW'(req_fire) - CW'(resp);

    if (redirect) begin
      fetch_pc_d = redirect_pc_al;
      resp_pc_d  = redirect_pc_al;
      // a response landing in the redirect cycle is already stale
      drop_d     = outst_q - CW'(resp);
    end else begin
      if (req_fire) fetch_pc_d = pc_next(fetch_pc_q);
      if (resp) begin
        if (drop_q != '0) drop_d = drop_q - CW'(1);
        else              resp_pc_d = pc_next(resp_pc_q);
      end
    end

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (redirect && (drop_d != '0)) state_d = FLUSH;
      FLUSH:   if (drop_d == '0) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: epoch-tagged memory model and expected instruction stream.
module tb_inst_fetch_unit;
  import if_pkg::*;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_unit_if #(.XLEN(XLEN)) ifc ();

  inst_fetch_unit #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .io    (ifc.master)
  );

  // A request remembers the redirect epoch it was issued in; a response from an
  // older epoch must never reach the IR stage.
  typedef struct {
    logic [31:0] addr;
    int          due;
    int          tag;
  } req_t;

  typedef struct {
    int          lat_hi;
    int          rdy;
    logic [31:0] rpc;
    logic [31:0] exp_pc;
    logic [31:0] exp_pc2;
  } vec_t;

  req_t        pend_q[$];
  logic [31:0] mfifo[$];
  int          epoch = 0;
  int          cyc = 0;
  bit          booting = 1'b0;
  logic [31:0] exp_req = RESET_PC;
  int          lat_lo = 1, lat_hi = 1, req_pct = 100, rdy_pct = 100;
  int          n_cmp = 0, n_bad = 0;
  int          fires = 0, pops = 0;
  logic [31:0] last_fire_addr = '0, last_pop_pc = '0;
  bit          popped_now = 1'b0;
  vec_t        vecs[6];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, check, then advance the model across the posedge.
  task automatic cycle(input bit redir, input logic [31:0] rpc);
    bit          rv, fire, pop, exp_rv;
    logic [31:0] faddr, ppc;
    req_t        e;
    rv = (pend_q.size() != 0) && (pend_q[0].due <= cyc);
    ifc.io_imem_resp_valid = rv;
    ifc.io_imem_resp_data  = rv ? memf(pend_q[0].addr) : 32'hDEAD_BEEF;
    ifc.io_imem_req_ready  = ($urandom_range(99) < req_pct);
    ifc.io_inst_ready      = ($urandom_range(99) < rdy_pct);
    ifc.io_redirect_valid  = redir;
    ifc.io_redirect_pc     = rpc;
    #1;
    exp_rv = !booting && !redir && ((mfifo.size() + pend_q.size()) < DEPTH);
    chk("req_valid", ifc.io_imem_req_valid, exp_rv);
    if (ifc.io_imem_req_valid) chk("req_addr", ifc.io_imem_req_addr, exp_req);
    chk("inst_valid", ifc.io_inst_valid, mfifo.size() != 0);
    chk("inst_pc", ifc.io_inst_pc, (mfifo.size() != 0) ? mfifo[0] : 32'h0);
    chk("inst", ifc.io_inst, (mfifo.size() != 0) ? memf(mfifo[0]) : 32'h0);
    fire  = ifc.io_imem_req_valid && ifc.io_imem_req_ready;
    faddr = ifc.io_imem_req_addr;
    pop   = ifc.io_inst_valid && ifc.io_inst_ready;
    ppc   = ifc.io_inst_pc;
    @(posedge clk);
    if (rv) e = pend_q.pop_front();
    if (redir) begin
      epoch++;
      mfifo.delete();
      exp_req = rpc & ~32'h3;
    end else begin
      if (pop) begin
        void'(mfifo.pop_front());
        pops++;
        last_pop_pc = ppc;
      end
      if (rv && (e.tag == epoch)) mfifo.push_back(e.addr);
      if (fire) begin
        pend_q.push_back('{faddr, cyc + int'($urandom_range(lat_hi, lat_lo)), epoch});
        exp_req = exp_req + 32'd4;
        fires++;
        last_fire_addr = faddr;
      end
    end
    popped_now = pop && !redir;
    booting = 1'b0;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    ifc.io_redirect_valid  = 1'b0;
    ifc.io_redirect_pc     = '0;
    ifc.io_imem_req_ready  = 1'b1;
    ifc.io_imem_resp_valid = 1'b0;
    ifc.io_imem_resp_data  = '0;
    ifc.io_inst_ready      = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_req_valid", ifc.io_imem_req_valid, 0);
    chk("rst_req_addr", ifc.io_imem_req_addr, RESET_PC);
    chk("rst_inst_valid", ifc.io_inst_valid, 0);
    chk("rst_inst", ifc.io_inst, 0);
    chk("rst_inst_pc", ifc.io_inst_pc, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pend_q.delete();
    mfifo.delete();
    epoch++;
    exp_req = RESET_PC;
    booting = 1'b1;
  endtask

  task automatic wait_pop(input string name, input logic [31:0] exp_pc, input int budget);
    int n;
    n = 0;
    popped_now = 1'b0;
    while (!popped_now && (n < budget)) begin
      cycle(1'b0, 32'h0);
      n++;
    end
    if (popped_now) chk(name, last_pop_pc, exp_pc);
    else begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no delivery within %0d cycles, expected pc %h", name, budget, exp_pc);
    end
  endtask

  initial begin
    vecs[0] = '{1, 100, 32'h0000_0100, 32'h0000_0100, 32'h0000_0104};
    vecs[1] = '{3,  50, 32'h0000_2002, 32'h0000_2000, 32'h0000_2004};
    vecs[2] = '{2,  70, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[3] = '{4,  30, 32'h1234_5677, 32'h1234_5674, 32'h1234_5678};
    vecs[4] = '{1,  90, 32'h8000_0001, 32'h8000_0000, 32'h8000_0004};
    vecs[5] = '{3, 100, 32'h0000_0040, 32'h0000_0040, 32'h0000_0044};

    @(negedge clk);
    do_reset();

    // streaming at one word per cycle
    lat_lo = 1; lat_hi = 1; req_pct = 100; rdy_pct = 100; pops = 0;
    repeat (20) cycle(1'b0, 32'h0);
    chk("t1_throughput", pops >= 15, 1);
    chk("t1_last_pc", last_pop_pc, 32'(pops - 1) * 32'd4);

    // IR stalled: credit caps issue at DEPTH, one pop frees one slot
    do_reset();
    rdy_pct = 0; fires = 0;
    repeat (12) cycle(1'b0, 32'h0);
    chk("t2_fires", fires, DEPTH);
    chk("t2_last_addr", last_fire_addr, 32'hC);
    rdy_pct = 100;
    cycle(1'b0, 32'h0);
    rdy_pct = 0; fires = 0;
    repeat (6) cycle(1'b0, 32'h0);
    chk("t2_refill_fires", fires, 1);
    chk("t2_refill_addr", last_fire_addr, 32'h10);

    // four requests in flight, redirect drops all of them
    do_reset();
    lat_lo = 4; lat_hi = 4; rdy_pct = 100;
    for (int i = 0; i < 20 && pend_q.size() < 4; i++) cycle(1'b0, 32'h0);
    chk("t3_in_flight", pend_q.size(), 4);
    cycle(1'b1, 32'h100);
    wait_pop("t3_first_pc", 32'h100, 100);

    // redirect in the same cycle as a response and a ready IR
    lat_lo = 2; lat_hi = 2; rdy_pct = 100;
    repeat (5) cycle(1'b0, 32'h0);
    for (int i = 0; i < 20 && !(pend_q.size() != 0 && pend_q[0].due <= cyc); i++)
      cycle(1'b0, 32'h0);
    chk("t4_resp_due", (pend_q.size() != 0) && (pend_q[0].due <= cyc), 1);
    cycle(1'b1, 32'h180);
    chk("t4_empty_after", ifc.io_inst_valid, 0);
    wait_pop("t4_first_pc", 32'h180, 100);

    // back-to-back redirects while flushing
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 20 && pend_q.size() < 2; i++) cycle(1'b0, 32'h0);
    cycle(1'b1, 32'h200);
    cycle(1'b1, 32'h300);
    wait_pop("t5_first_pc", 32'h300, 100);

    // reset mid-stream
    lat_lo = 1; lat_hi = 2; req_pct = 80; rdy_pct = 70;
    repeat (10) cycle(1'b0, 32'h0);
    do_reset();
    wait_pop("t6_first_pc", RESET_PC, 100);

    // table of redirect targets under randomized traffic
    for (int i = 0; i < 6; i++) begin
      lat_lo = 1; lat_hi = vecs[i].lat_hi; rdy_pct = vecs[i].rdy; req_pct = 80;
      repeat (30) cycle($urandom_range(99) < 5, $urandom);
      cycle(1'b1, vecs[i].rpc);
      wait_pop($sformatf("vec%0d_first_pc", i), vecs[i].exp_pc, 200);
      wait_pop($sformatf("vec%0d_second_pc", i), vecs[i].exp_pc2, 200);
    end

    // long randomized run
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) begin
        lat_hi  = int'($urandom_range(5, 1));
        req_pct = int'($urandom_range(100, 30));
        rdy_pct = int'($urandom_range(100, 20));
      end
      cycle($urandom_range(99) < 4, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
